// File: rtl/counter_pkg.sv
// Shared types and defaults for the up/down counter monitor.
package counter_pkg;

  localparam int unsigned COUNT_W = 8;

  typedef enum logic [1:0] {
    StIdle,
    StSync,
    StCheck
  } state_e;

endpackage

// File: rtl/counter_model.sv
// Combinational reference of a WIDTH-bit up/down counter: next value and wrap flag.
module counter_model
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = COUNT_W
) (
  input  logic [WIDTH-1:0] cur,
  input  logic             enable,
  input  logic             up_down,
  output logic [WIDTH-1:0] nxt,
  output logic             wrap
);

  always_comb begin
    nxt  = cur;
    wrap = 1'b0;
    if (enable) begin
      if (up_down) begin
        nxt  = cur + WIDTH'(1);
        wrap = &cur;
      end else begin
        nxt  = cur - WIDTH'(1);
        wrap = ~|cur;
      end
    end
  end

endmodule

// File: rtl/counter_monitor.sv
// Locks onto an up/down counter, predicts its count/overflow each cycle and
// records mismatches, first failing values and observed wraps.
module counter_monitor
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = COUNT_W,
  parameter int unsigned ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             up_down,
  input  logic [WIDTH-1:0] count,
  input  logic             overflow,
  input  logic             check_en,
  input  logic             clr_err,
  output logic             locked,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] first_exp,
  output logic [WIDTH-1:0] first_obs,
  output logic [15:0]      wrap_count
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic             exp_ovf_q, exp_ovf_d;
  logic             mismatch_q;
  logic [ERR_W-1:0] err_q;
  logic [WIDTH-1:0] first_exp_q, first_obs_q;
  logic [15:0]      wrap_q;

  logic             fail;
  logic             checking;
  logic [WIDTH-1:0] model_cur, model_nxt;
  logic             model_wrap;

  counter_model #(
    .WIDTH(WIDTH)
  ) u_model (
    .cur    (model_cur),
    .enable (enable),
    .up_down(up_down),
    .nxt    (model_nxt),
    .wrap   (model_wrap)
  );

  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    exp_ovf_d = exp_ovf_q;
    checking  = (state_q == StCheck) && check_en;
    fail      = checking && ((count != exp_q) || (overflow != exp_ovf_q));
    // Predict from the observed count while syncing or after a failure so one
    // fault is reported once.
    model_cur = (checking && !fail) ? exp_q : count;

    unique case (state_q)
      StIdle:  if (check_en) state_d = StSync;
      StSync:  state_d = check_en ? StCheck : StIdle;
      StCheck: if (!check_en) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (check_en && (state_q != StIdle)) begin
      exp_d     = model_nxt;
      exp_ovf_d = model_wrap;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      exp_q       <= '0;
      exp_ovf_q   <= 1'b0;
      mismatch_q  <= 1'b0;
      err_q       <= '0;
      first_exp_q <= '0;
      first_obs_q <= '0;
      wrap_q      <= '0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      exp_ovf_q  <= exp_ovf_d;
      mismatch_q <= fail;
      if (clr_err) begin
        err_q       <= '0;
        first_exp_q <= '0;
        first_obs_q <= '0;
        wrap_q      <= '0;
      end else begin
        if (fail) begin
          if (err_q != '1) err_q <= err_q + ERR_W'(1);
          if (err_q == '0) begin
            first_exp_q <= exp_q;
            first_obs_q <= count;
          end
        end
        if (checking && overflow && (wrap_q != '1)) wrap_q <= wrap_q + 16'd1;
      end
    end
  end

  assign locked     = (state_q == StCheck);
  assign mismatch   = mismatch_q;
  assign err_count  = err_q;
  assign first_exp  = first_exp_q;
  assign first_obs  = first_obs_q;
  assign wrap_count = wrap_q;

endmodule
